fifo_uart_tx: RTL

Serial drain stage placed directly downstream of the byte FIFO. It pops one byte at a time from the FIFO read port and shifts each byte out as a UART frame: start bit, WIDTH data bits LSB first, optional even parity, one stop bit. Frames are sent back-to-back while the FIFO is non-empty, so the FIFO is emptied at line rate.

---
 rtl/fifo_uart_tx_pkg.sv | 19 +
 rtl/fifo_uart_tx_baud_gen.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared types and line constants for the FIFO-draining UART
// transmitter. The PARITY state only exists when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_t;

   // Idle/stop level and start-bit level of the serial line.
   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter. Counts
// 0..CLKS_PER_BIT-1 while run is high and flags the final cycle of each bit.
// clr restarts the count so a new frame always begins on a full bit period.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic run,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Last cycle of a bit period; only meaningful while the line is active.
   assign bit_end = run & (cnt_q == LAST_CNT);

   // Next count: clear wins, otherwise wrap at the end of each bit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and serialises each one as a
// UART frame (start, WIDTH data bits LSB first, optional even parity, stop).
// Frames run back-to-back while the FIFO has data and tx_en is high.
// Define FIFO_UART_TX_PARITY_EN to add the even-parity bit.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   tx_state_t        state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [BW-1:0]    bit_cnt_q;
   logic             tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             parity_q;
`endif

   logic fetch;
   logic last_stop;
   logic load;
   logic bit_end;

   // A new byte is taken from idle, or on the final stop-bit cycle so the
   // next start bit follows with no gap. Reset blocks the pop so a byte is
   // never lost to a frame that is about to be cancelled.
   assign fetch      = tx_en & ~fifo_empty;
   assign last_stop  = (state_q == ST_STOP) & bit_end;
   assign load       = ~reset & fetch & ((state_q == ST_IDLE) | last_stop);
   assign fifo_rd_en = load;
   assign frame_done = ~reset & last_stop;
   assign busy       = (state_q != ST_IDLE);
   assign tx         = tx_q;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clr     (load | (state_q == ST_IDLE)),
      .run     (state_q != ST_IDLE),
      .bit_end (bit_end)
   );

   // Frame sequencer: state, shift register, bit counter and the registered
   // line level, which is updated on the edge that enters each bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tx_q      <= LINE_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else if (load) begin
         state_q   <= ST_START;
         tx_q      <= LINE_START;
         shreg_q   <= fifo_data;
         bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= ^fifo_data;
`endif
      end else if (bit_end) begin
         case (state_q)
            ST_START: begin
               state_q <= ST_DATA;
               tx_q    <= shreg_q[0];
            end
            ST_DATA: begin
               shreg_q <= shreg_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                  state_q   <= ST_PARITY;
                  tx_q      <= parity_q;
`else
                  state_q   <= ST_STOP;
                  tx_q      <= LINE_IDLE;
`endif
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  tx_q      <= shreg_q[1];
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
               state_q <= ST_STOP;
               tx_q    <= LINE_IDLE;
            end
`endif
            ST_STOP: begin
               // Reached only when no fetch happened on the last stop cycle.
               state_q <= ST_IDLE;
               tx_q    <= LINE_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= LINE_IDLE;
            end
         endcase
      end
   end

endmodule
